// File: rtl/mem_arbiter_if.sv
`default_nettype none
// ============================================================================
//  Module      : mem_arbiter_if
//  Description : Bus bundle for the fetch/data memory arbiter.
//                Fetch port  : i_re, i_addr, i_sel   -> i_data, i_ack
//                Data port   : d_re, d_we, d_addr, d_sel, d_wdata
//                                                    -> d_rdata, d_ack
//                Memory side : m_re, m_we, m_addr, m_sel, m_wdata
//                                                    <- m_rdata, m_ack
//                master : arbiter view (drives acks and memory strobes)
//                slave  : environment view (requesters plus memory)
//  Revision    : 1.0  initial release
// ============================================================================
interface mem_arbiter_if;
    // fetch requester
    logic        i_re;
    logic [31:0] i_addr;
    logic [3:0]  i_sel;
    logic [31:0] i_data;
    logic        i_ack;
    // data requester
    logic        d_re;
    logic        d_we;
    logic [31:0] d_addr;
    logic [3:0]  d_sel;
    logic [31:0] d_wdata;
    logic [31:0] d_rdata;
    logic        d_ack;
    // memory side
    logic        m_re;
    logic        m_we;
    logic [31:0] m_addr;
    logic [3:0]  m_sel;
    logic [31:0] m_wdata;
    logic [31:0] m_rdata;
    logic        m_ack;

    modport master (
        input  i_re, i_addr, i_sel,
        output i_data, i_ack,
        input  d_re, d_we, d_addr, d_sel, d_wdata,
        output d_rdata, d_ack,
        output m_re, m_we, m_addr, m_sel, m_wdata,
        input  m_rdata, m_ack
    );

    modport slave (
        output i_re, i_addr, i_sel,
        input  i_data, i_ack,
        output d_re, d_we, d_addr, d_sel, d_wdata,
        input  d_rdata, d_ack,
        input  m_re, m_we, m_addr, m_sel, m_wdata,
        output m_rdata, m_ack
    );
endinterface
`default_nettype wire

// File: rtl/mem_arbiter.sv
`default_nettype none
// ============================================================================
//  Module      : mem_arbiter
//  Description : Shares one memory bus between the instruction-fetch port and
//                the load/store port. Data has priority; after STARVE_LIMIT
//                consecutive data grants with fetch waiting, fetch is forced.
//                A watchdog ends transactions that see no m_ack for TIMEOUT
//                owner cycles (acks the owner with zero data, pulses
//                timeout_err).
//  Ports       : clk         clock, rising edge
//                reset_n     asynchronous active-low reset
//                bus         mem_arbiter_if.master (requesters + memory)
//                timeout_err one-cycle pulse on watchdog termination
//  Parameters  : STARVE_LIMIT (0 = strict data priority)
//                TIMEOUT      (0 = watchdog disabled)
//  Revision    : 1.0  initial release
// ============================================================================
module mem_arbiter #(
    parameter int unsigned STARVE_LIMIT = 4,
    parameter int unsigned TIMEOUT      = 255
) (
    input  wire logic         clk,
    input  wire logic         reset_n,
    mem_arbiter_if.master     bus,
    output logic              timeout_err
);

    localparam logic [1:0] c_st_idle   = 2'd0;
    localparam logic [1:0] c_st_ifetch = 2'd1;
    localparam logic [1:0] c_st_data   = 2'd2;

    localparam int c_sw = (STARVE_LIMIT > 0) ? $clog2(STARVE_LIMIT + 1) : 1;
    localparam int c_ww = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;

    localparam logic [c_sw-1:0] c_starve_max = c_sw'(STARVE_LIMIT);
    localparam logic [c_ww-1:0] c_wd_last    = c_ww'(TIMEOUT - 1);
    localparam bit              c_strict     = (STARVE_LIMIT == 0);
    localparam bit              c_wd_en      = (TIMEOUT != 0);

    logic [1:0]      r_state;
    logic [c_sw-1:0] r_starve_cnt;
    logic [c_ww-1:0] r_wd_cnt;
    logic            r_m_re;
    logic            r_m_we;
    logic [31:0]     r_m_addr;
    logic [3:0]      r_m_sel;
    logic [31:0]     r_m_wdata;

    logic w_d_req;
    logic w_grant_d;
    logic w_grant_i;
    logic w_owner;
    logic w_expire;
    logic w_done;

    assign w_d_req   = bus.d_re | bus.d_we;
    // Data wins unless fetch is waiting and has already been passed over
    // STARVE_LIMIT times in a row.
    assign w_grant_d = (r_state == c_st_idle) && w_d_req &&
                       (c_strict || (r_starve_cnt < c_starve_max) || !bus.i_re);
    assign w_grant_i = (r_state == c_st_idle) && !w_grant_d && bus.i_re;
    assign w_owner   = (r_state == c_st_ifetch) || (r_state == c_st_data);
    // A real m_ack in the expiry cycle takes precedence over the watchdog.
    assign w_expire  = c_wd_en && w_owner && (r_wd_cnt == c_wd_last) && !bus.m_ack;
    assign w_done    = w_owner && (bus.m_ack || w_expire);

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_state      <= c_st_idle;
            r_starve_cnt <= '0;
            r_wd_cnt     <= '0;
            r_m_re       <= 1'b0;
            r_m_we       <= 1'b0;
            r_m_addr     <= '0;
            r_m_sel      <= '0;
            r_m_wdata    <= '0;
        end else begin
            case (r_state)
                c_st_idle: begin
                    if (w_grant_d) begin
                        r_state   <= c_st_data;
                        r_wd_cnt  <= '0;
                        // read+write together is treated as a write
                        r_m_re    <= bus.d_re & ~bus.d_we;
                        r_m_we    <= bus.d_we;
                        r_m_addr  <= bus.d_addr;
                        r_m_sel   <= bus.d_sel;
                        r_m_wdata <= bus.d_wdata;
                        if (bus.i_re) begin
                            if (r_starve_cnt != c_starve_max) begin
                                r_starve_cnt <= r_starve_cnt + 1'b1;
                            end
                        end else begin
                            r_starve_cnt <= '0;
                        end
                    end else if (w_grant_i) begin
                        r_state      <= c_st_ifetch;
                        r_wd_cnt     <= '0;
                        r_starve_cnt <= '0;
                        r_m_re       <= 1'b1;
                        r_m_we       <= 1'b0;
                        r_m_addr     <= bus.i_addr;
                        r_m_sel      <= bus.i_sel;
                        r_m_wdata    <= '0;
                    end
                end
                c_st_ifetch, c_st_data: begin
                    if (w_done) begin
                        r_state   <= c_st_idle;
                        r_m_re    <= 1'b0;
                        r_m_we    <= 1'b0;
                        r_m_addr  <= '0;
                        r_m_sel   <= '0;
                        r_m_wdata <= '0;
                    end else if (c_wd_en) begin
                        r_wd_cnt <= r_wd_cnt + 1'b1;
                    end
                end
                default: begin
                    r_state <= c_st_idle;
                end
            endcase
        end
    end

    assign bus.m_re    = r_m_re;
    assign bus.m_we    = r_m_we;
    assign bus.m_addr  = r_m_addr;
    assign bus.m_sel   = r_m_sel;
    assign bus.m_wdata = r_m_wdata;

    // Acks and read data are steered combinationally from the owner state,
    // so an m_ack seen while idle never reaches a requester.
    assign bus.i_ack   = (r_state == c_st_ifetch) && (bus.m_ack || w_expire);
    assign bus.d_ack   = (r_state == c_st_data)   && (bus.m_ack || w_expire);
    assign bus.i_data  = ((r_state == c_st_ifetch) && bus.m_ack) ? bus.m_rdata : '0;
    assign bus.d_rdata = ((r_state == c_st_data)   && bus.m_ack) ? bus.m_rdata : '0;
    assign timeout_err = w_expire;

endmodule
`default_nettype wire

// File: tb/tb_mem_arbiter.sv
`default_nettype none
// ============================================================================
//  Module      : tb_mem_arbiter
//  Description : Self-checking bench for mem_arbiter. The bench plays both
//                requesters and the memory; a transaction-level model predicts
//                which requester owns each grant, the latched bus fields, and
//                the ack/rdata/timeout outcome from the chosen memory latency.
//  Revision    : 1.0  initial release
// ============================================================================
module tb_mem_arbiter;

    localparam int STV = 4;
    localparam int TMO = 8;

    logic clk;
    logic reset_n;
    logic timeout_err;

    mem_arbiter_if bus();

    mem_arbiter #(
        .STARVE_LIMIT (STV),
        .TIMEOUT      (TMO)
    ) dut (
        .clk         (clk),
        .reset_n     (reset_n),
        .bus         (bus),
        .timeout_err (timeout_err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_checks = 0;
    int n_err    = 0;
    int starve   = 0;   // consecutive data grants taken while fetch waited

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // Called at a negedge with the arbiter idle and at least one request up.
    // lat = owner cycles before the ack cycle; lat >= TMO means no m_ack.
    task automatic do_txn(input int lat, input logic [31:0] rd, output bit owner_d);
        logic [31:0] e_addr;
        logic [31:0] e_wdata;
        logic [3:0]  e_sel;
        logic        e_re;
        logic        e_we;
        bit          expire;
        bit          done;
        int          end_cyc;
        int          c;

        owner_d = (bus.d_re | bus.d_we) && (starve < STV || !bus.i_re);
        if (owner_d) begin
            e_addr  = bus.d_addr;
            e_sel   = bus.d_sel;
            e_we    = bus.d_we;
            e_re    = !bus.d_we;
            e_wdata = bus.d_wdata;
            starve  = bus.i_re ? ((starve < STV) ? starve + 1 : STV) : 0;
        end else begin
            e_addr  = bus.i_addr;
            e_sel   = bus.i_sel;
            e_we    = 1'b0;
            e_re    = 1'b1;
            e_wdata = '0;
            starve  = 0;
        end
        expire  = (lat >= TMO);
        end_cyc = expire ? TMO : lat + 1;

        @(posedge clk);
        @(negedge clk);
        chk("grant_m_re",   bus.m_re,   e_re);
        chk("grant_m_we",   bus.m_we,   e_we);
        chk("grant_m_addr", bus.m_addr, e_addr);
        chk("grant_m_sel",  bus.m_sel,  e_sel);
        if (e_we) chk("grant_m_wdata", bus.m_wdata, e_wdata);

        // owner changes its inputs mid-transaction; bus must not follow
        if (owner_d) begin
            bus.d_addr  = $urandom;
            bus.d_wdata = $urandom;
        end else begin
            bus.i_addr = $urandom;
        end

        c    = 1;
        done = 1'b0;
        while (!done) begin
            if (!expire && c == end_cyc) begin
                bus.m_ack   = 1'b1;
                bus.m_rdata = rd;
            end
            #1;
            if (c == end_cyc) begin
                chk("own_ack",   owner_d ? bus.d_ack : bus.i_ack, 1);
                chk("other_ack", owner_d ? bus.i_ack : bus.d_ack, 0);
                chk("own_rdata", owner_d ? bus.d_rdata : bus.i_data, expire ? 32'h0 : rd);
                chk("other_rdata", owner_d ? bus.i_data : bus.d_rdata, 0);
                chk("timeout_err", timeout_err, expire);
                done = 1'b1;
            end else begin
                chk("wait_i_ack", bus.i_ack, 0);
                chk("wait_d_ack", bus.d_ack, 0);
                chk("wait_tmo",   timeout_err, 0);
                chk("hold_addr",  bus.m_addr, e_addr);
                @(negedge clk);
                c++;
            end
        end

        if (owner_d) begin
            bus.d_re = 1'b0;
            bus.d_we = 1'b0;
        end else begin
            bus.i_re = 1'b0;
        end

        // idle cycle: m_ack may still be high here and must be ignored
        @(posedge clk);
        @(negedge clk);
        chk("idle_m_re",  bus.m_re,  0);
        chk("idle_m_we",  bus.m_we,  0);
        chk("idle_i_ack", bus.i_ack, 0);
        chk("idle_d_ack", bus.d_ack, 0);
        bus.m_ack = 1'b0;
    endtask

    task automatic new_reqs();
        int op;
        if (!bus.i_re && $urandom_range(0, 1) == 1) begin
            bus.i_re   = 1'b1;
            bus.i_addr = $urandom;
            bus.i_sel  = 4'($urandom);
        end
        if (!(bus.d_re | bus.d_we) && $urandom_range(0, 1) == 1) begin
            op          = $urandom_range(0, 2);
            bus.d_re    = (op != 1);
            bus.d_we    = (op != 0);
            bus.d_addr  = $urandom;
            bus.d_sel   = 4'($urandom);
            bus.d_wdata = $urandom;
        end
        if (!bus.i_re && !(bus.d_re | bus.d_we)) begin
            bus.i_re   = 1'b1;
            bus.i_addr = $urandom;
            bus.i_sel  = 4'($urandom);
        end
    endtask

    initial begin
        bit          o;
        logic [9:0]  order;

        bus.i_re = 0; bus.i_addr = 0; bus.i_sel = 0;
        bus.d_re = 0; bus.d_we = 0; bus.d_addr = 0; bus.d_sel = 0; bus.d_wdata = 0;
        bus.m_rdata = 0; bus.m_ack = 0;
        reset_n = 1'b0;

        // reset with both requests asserted
        bus.i_re = 1'b1;
        bus.d_re = 1'b1;
        repeat (3) @(negedge clk);
        chk("rst_m_re",    bus.m_re,    0);
        chk("rst_m_we",    bus.m_we,    0);
        chk("rst_m_addr",  bus.m_addr,  0);
        chk("rst_m_sel",   bus.m_sel,   0);
        chk("rst_m_wdata", bus.m_wdata, 0);
        chk("rst_i_ack",   bus.i_ack,   0);
        chk("rst_d_ack",   bus.d_ack,   0);
        chk("rst_i_data",  bus.i_data,  0);
        chk("rst_d_rdata", bus.d_rdata, 0);
        chk("rst_tmo",     timeout_err, 0);
        bus.i_re = 1'b0;
        bus.d_re = 1'b0;
        reset_n  = 1'b1;
        @(negedge clk);
        starve = 0;

        // fetch only, memory acks two cycles after m_re
        bus.i_re   = 1'b1;
        bus.i_addr = 32'h100;
        bus.i_sel  = 4'hF;
        do_txn(2, 32'hDEADBEEF, o);
        chk("fetch_owner", 32'(o), 0);

        // contention: data write first, then the fetch
        bus.i_re    = 1'b1;
        bus.i_addr  = 32'h300;
        bus.i_sel   = 4'hF;
        bus.d_we    = 1'b1;
        bus.d_addr  = 32'h2000;
        bus.d_sel   = 4'h3;
        bus.d_wdata = 32'h55AA55AA;
        do_txn(1, $urandom, o);
        chk("cont_first_data", 32'(o), 1);
        do_txn(1, $urandom, o);
        chk("cont_then_fetch", 32'(o), 0);

        // starvation: both held, immediate ack
        order = '0;
        bus.i_re = 1'b1;
        bus.d_re = 1'b1;
        for (int k = 0; k < 10; k++) begin
            do_txn(0, $urandom, o);
            order = {order[8:0], o};
            if (o) bus.d_re = 1'b1;
            else   bus.i_re = 1'b1;
        end
        chk("starve_order", 32'(order), 32'b1111011110);
        bus.i_re = 1'b0;
        bus.d_re = 1'b0;
        @(negedge clk);

        // watchdog expiry, then ack on the last allowed cycle
        bus.d_re   = 1'b1;
        bus.d_addr = 32'h40;
        do_txn(TMO + 5, 32'hFFFFFFFF, o);
        chk("tmo_owner", 32'(o), 1);
        bus.d_re   = 1'b1;
        bus.d_addr = 32'h44;
        do_txn(TMO - 1, 32'h12345678, o);

        // randomized mix
        for (int k = 0; k < 40; k++) begin
            new_reqs();
            do_txn($urandom_range(0, 10), $urandom, o);
        end
        bus.i_re = 1'b0;
        bus.d_re = 1'b0;
        bus.d_we = 1'b0;
        @(negedge clk);

        // reset in the middle of a data transaction
        bus.d_re   = 1'b1;
        bus.d_addr = 32'h80;
        @(posedge clk);
        @(negedge clk);
        chk("mid_m_re", bus.m_re, 1);
        bus.m_ack   = 1'b1;
        bus.m_rdata = 32'hCAFEF00D;
        #1;
        chk("mid_d_ack_pre", bus.d_ack, 1);
        #1;
        reset_n = 1'b0;
        #1;
        chk("mid_m_re_drop",  bus.m_re,    0);
        chk("mid_d_ack_drop", bus.d_ack,   0);
        chk("mid_d_rdata",    bus.d_rdata, 0);
        bus.d_re = 1'b0;
        @(negedge clk);
        reset_n = 1'b1;
        starve  = 0;
        @(posedge clk);
        @(negedge clk);
        chk("post_i_ack", bus.i_ack, 0);
        chk("post_d_ack", bus.d_ack, 0);
        chk("post_m_re",  bus.m_re,  0);
        bus.m_ack = 1'b0;
        @(negedge clk);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_err);
        $finish;
    end

endmodule
`default_nettype wire
